// File: rtl/sin_ctrl.sv
// Control unit and valid/ready stream wrapper for the sinDU Maclaurin datapath.
// Sequences LOAD plus seven MULX/MULL/ACC iterations, then registers the sum.
module sin_ctrl #(
    parameter int XW = 16,
    parameter int RW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] r_out,
    output logic          busy,
    output logic [XW-1:0] xBus,
    output logic          cntUp,
    output logic          init0,
    output logic          ldX,
    output logic          ldT,
    output logic          initT1,
    output logic          ldS,
    output logic          initS1,
    output logic          selXR,
    input  logic          cnt8,
    input  logic [RW-1:0] rBus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MULX = 3'd2,
        MULL = 3'd3,
        ACC  = 3'd4,
        WB   = 3'd5
    } state_t;

    state_t state, state_next;
    logic   wb_fire;

    assign xBus = x_in;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        cntUp      = 1'b0;
        init0      = 1'b0;
        ldX        = 1'b0;
        ldT        = 1'b0;
        initT1     = 1'b0;
        ldS        = 1'b0;
        initS1     = 1'b0;
        selXR      = 1'b0;
        wb_fire    = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                // Accept strobes are masked during reset so sinDU sees no load while rst is high.
                if (in_valid && !rst) begin
                    ldX        = 1'b1;
                    init0      = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                initT1     = 1'b1;
                initS1     = 1'b1;
                state_next = MULX;
            end
            MULX: begin
                selXR      = 1'b1;
                ldT        = 1'b1;
                state_next = MULL;
            end
            MULL: begin
                ldT        = 1'b1;
                cntUp      = 1'b1;
                state_next = ACC;
            end
            ACC: begin
                ldS        = 1'b1;
                state_next = cnt8 ? WB : MULX;
            end
            WB: begin
                // Holding here with all strobes low freezes sinDU until the output slot frees.
                if (!out_valid || out_ready) begin
                    wb_fire    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A reload from WB takes priority over the consumer draining the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            r_out     <= '0;
        end else if (wb_fire) begin
            out_valid <= 1'b1;
            r_out     <= rBus;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sin_ctrl.sv
// Directed bench for sin_ctrl with a behavioural sinDU stand-in driving cnt8/rBus.
module tb_sin_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] r_out;
    logic        busy;
    logic [15:0] xBus;
    logic        cntUp, init0, ldX, ldT, initT1, ldS, initS1, selXR;
    logic        cnt8;
    logic [17:0] rBus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sin_ctrl #(.XW(16), .RW(18)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .r_out(r_out),
        .busy(busy), .xBus(xBus),
        .cntUp(cntUp), .init0(init0), .ldX(ldX), .ldT(ldT),
        .initT1(initT1), .ldS(ldS), .initS1(initS1), .selXR(selXR),
        .cnt8(cnt8), .rBus(rBus)
    );

    // Fixed-point stand-in for sinDU: x is Q2.14, LUT[c] = 1/((2c+2)(2c+3)) in Q0.16.
    function automatic logic [15:0] lut(input logic [2:0] c);
        case (c)
            3'd0:    return 16'd10923;
            3'd1:    return 16'd3277;
            3'd2:    return 16'd1560;
            3'd3:    return 16'd910;
            3'd4:    return 16'd596;
            3'd5:    return 16'd420;
            default: return 16'd312;
        endcase
    endfunction

    function automatic logic [17:0] mul_x2(input logic [17:0] t, input logic [15:0] x);
        logic [63:0] p;
        p = 64'(t) * 64'(x) * 64'(x);
        return 18'(p >> 28);
    endfunction

    function automatic logic [17:0] mul_lut(input logic [17:0] t, input logic [2:0] c);
        logic [63:0] p;
        p = 64'(t) * 64'(lut(c));
        return 18'(p >> 16);
    endfunction

    function automatic logic [17:0] golden(input logic [15:0] x);
        logic [17:0] t, s;
        t = {2'b00, x};
        s = {2'b00, x};
        for (int c = 0; c < 7; c++) begin
            t = mul_x2(t, x);
            t = mul_lut(t, 3'(c));
            if (((c + 1) % 2) == 1) s = s - t;
            else                    s = s + t;
        end
        return s;
    endfunction

    logic [2:0]  m_cnt;
    logic [15:0] m_x;
    logic [17:0] m_t, m_s;

    assign cnt8 = (m_cnt == 3'd7);
    assign rBus = m_s;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= '0;
            m_x   <= '0;
            m_t   <= '0;
            m_s   <= '0;
        end else begin
            if (ldX) m_x <= xBus;
            if (init0)      m_cnt <= '0;
            else if (cntUp) m_cnt <= m_cnt + 3'd1;
            if (initT1)   m_t <= {2'b00, m_x};
            else if (ldT) m_t <= selXR ? mul_x2(m_t, m_x) : mul_lut(m_t, m_cnt);
            if (initS1)   m_s <= {2'b00, m_x};
            else if (ldS) m_s <= m_cnt[0] ? (m_s - m_t) : (m_s + m_t);
        end
    end

    // Strobe activity counters, sampled with pre-edge values.
    int n_ldt = 0, n_lds = 0, n_cntup = 0, n_ldx = 0, n_any = 0;
    int n_overlap = 0, n_busy_ready = 0, n_lds_bad = 0, lds_idx = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (ldT)   n_ldt++;
            if (cntUp) n_cntup++;
            if (ldX) begin
                n_ldx++;
                lds_idx = 0;
            end
            if (ldS) begin
                n_lds++;
                lds_idx++;
                if (int'(m_cnt) != lds_idx) n_lds_bad++;
            end
            if ({cntUp, init0, ldX, ldT, initT1, ldS, initS1, selXR} != 8'h00) n_any++;
            if ((ldT && initT1) || (ldS && initS1)) n_overlap++;
            if (busy && in_ready) n_busy_ready++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer x, count edges from the accept edge (inclusive) to out_valid seen high.
    task automatic run_op(input logic [15:0] x, output int edges);
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          s_ldt, s_lds, s_cnt, s_ldx, s_any;
        int          hold_bad;
        logic [17:0] g1;

        // 1: reset with in_valid held high
        rst       = 1'b1;
        in_valid  = 1'b1;
        x_in      = 16'h1234;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_r_out", 32'(r_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobes", 32'({cntUp, init0, ldX, ldT, initT1, ldS, initS1, selXR}), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // 2: x=0, strobe counts and latency
        s_ldt = n_ldt; s_lds = n_lds; s_cnt = n_cntup; s_ldx = n_ldx;
        run_op(16'h0000, lat);
        check("zero_latency", 32'(lat), 32'd24);
        check("zero_ldT", 32'(n_ldt - s_ldt), 32'd14);
        check("zero_ldS", 32'(n_lds - s_lds), 32'd7);
        check("zero_cntUp", 32'(n_cntup - s_cnt), 32'd7);
        check("zero_ldX", 32'(n_ldx - s_ldx), 32'd1);
        check("zero_r_out", 32'(r_out), 32'd0);

        // 3: x=1.0, bit-exact against the golden series and sign order
        run_op(16'h4000, lat);
        check("one_latency", 32'(lat), 32'd24);
        check("one_r_out", 32'(r_out), 32'(golden(16'h4000)));
        check("one_sign_order", 32'(n_lds_bad), 32'd0);

        // 4: output stall with a second argument in flight
        @(negedge clk);
        out_ready = 1'b0;
        run_op(16'h2000, lat);
        g1 = golden(16'h2000);
        check("stall_r1", 32'(r_out), 32'(g1));
        in_valid = 1'b1;
        x_in     = 16'h6000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_accept2", 32'(busy), 32'd1);
        hold_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r_out !== g1 || out_valid !== 1'b1) hold_bad++;
        end
        check("stall_hold", 32'(hold_bad), 32'd0);
        s_any = n_any;
        repeat (3) @(negedge clk);
        check("stall_no_strobes", 32'(n_any - s_any), 32'd0);
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_reload_valid", 32'(out_valid), 32'd1);
        check("stall_r2", 32'(r_out), 32'(golden(16'h6000)));
        @(negedge clk);
        check("stall_drain", 32'(out_valid), 32'd0);

        // 5: in_valid held while busy
        s_ldx    = n_ldx;
        in_valid = 1'b1;
        x_in     = 16'h1000;
        @(posedge clk);
        @(negedge clk);
        x_in = 16'h3000;
        lat  = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("busy_no_ready", 32'(n_busy_ready), 32'd0);
        check("busy_ldx_count", 32'(n_ldx - s_ldx), 32'd1);
        check("busy_r_out", 32'(r_out), 32'(golden(16'h1000)));
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_reaccept", 32'(busy), 32'd1);
        check("busy_ldx_after", 32'(n_ldx - s_ldx), 32'd2);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("busy_r_out2", 32'(r_out), 32'(golden(16'h3000)));

        // 6: reset during MULL of iteration 3
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'h5000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        s_cnt    = n_cntup;
        lat      = 0;
        while (!(cntUp && (n_cntup - s_cnt) == 2) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("mid_reached_mull3", 32'(cntUp), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_strobes", 32'({cntUp, init0, ldX, ldT, initT1, ldS, initS1, selXR}), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_r_out", 32'(r_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        run_op(16'h5000, lat);
        check("mid_latency", 32'(lat), 32'd24);
        check("mid_r_out", 32'(r_out), 32'(golden(16'h5000)));
        check("never_overlap", 32'(n_overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
